fsm_control: RTL

Main control state machine for the output FIFO stage; sits directly upstream of the pop counter.
- Supplies the `idle` flag the counter qualifies with `req`.
- Owns the almost-full/almost-empty thresholds driven to every output FIFO.
- Moore FSM over five states; watches per-FIFO empty and error flags.
- Latches which FIFO caused a fault.

---
 rtl/fsm_control_pkg.sv | 44 ++++
 rtl/fsm_control_if.sv | 36 +++
 rtl/fsm_control_threshold_regs.sv | 42 ++++
 rtl/fsm_control.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fsm_control_pkg.sv
// ============================================================================
// Module   : fsm_control_pkg
// Brief    : State encodings, widths and a clog2 helper for fsm_control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fsm_control_pkg;

    localparam int ESTADO_W = 3;

    localparam logic [ESTADO_W-1:0] ST_RESET  = 3'd0;
    localparam logic [ESTADO_W-1:0] ST_INIT   = 3'd1;
    localparam logic [ESTADO_W-1:0] ST_IDLE   = 3'd2;
    localparam logic [ESTADO_W-1:0] ST_ACTIVE = 3'd3;
    localparam logic [ESTADO_W-1:0] ST_ERROR  = 3'd4;

    typedef enum logic [ESTADO_W-1:0] {
        S_RESET  = ST_RESET,
        S_INIT   = ST_INIT,
        S_IDLE   = ST_IDLE,
        S_ACTIVE = ST_ACTIVE,
        S_ERROR  = ST_ERROR
    } state_e;

    // Never returns less than 1 so it can size a counter directly.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fsm_control_if.sv
// ============================================================================
// Module   : fsm_control_if
// Brief    : Configuration, FIFO status and control outputs of fsm_control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fsm_control_if #(
    parameter int FIFO_UNITS = 4,
    parameter int THR_WIDTH  = 3
);
    logic                  init;
    logic [THR_WIDTH-1:0]  umbral_alto_in;
    logic [THR_WIDTH-1:0]  umbral_bajo_in;
    logic [FIFO_UNITS-1:0] fifo_empty;
    logic [FIFO_UNITS-1:0] fifo_error;
    logic [THR_WIDTH-1:0]  umbral_alto;
    logic [THR_WIDTH-1:0]  umbral_bajo;
    logic                  idle;
    logic                  active;
    logic                  error;
    logic [FIFO_UNITS-1:0] error_src;
    logic [2:0]            estado;

    modport master (
        output init, umbral_alto_in, umbral_bajo_in, fifo_empty, fifo_error,
        input  umbral_alto, umbral_bajo, idle, active, error, error_src, estado
    );

    modport slave (
        input  init, umbral_alto_in, umbral_bajo_in, fifo_empty, fifo_error,
        output umbral_alto, umbral_bajo, idle, active, error, error_src, estado
    );
endinterface

`default_nettype wire

// File: rtl/fsm_control_threshold_regs.sv
// ============================================================================
// Module   : fsm_control_threshold_regs
// Brief    : INIT-gated almost-full/almost-empty threshold registers plus the
//            unsigned range check used when leaving INIT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_control_threshold_regs #(
    parameter int THR_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic [THR_WIDTH-1:0] alto_i,
    input  logic [THR_WIDTH-1:0] bajo_i,
    output logic [THR_WIDTH-1:0] alto_o,
    output logic [THR_WIDTH-1:0] bajo_o,
    output logic                 cfg_ok_o
);

    logic [THR_WIDTH-1:0] alto_q;
    logic [THR_WIDTH-1:0] bajo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            alto_q <= '0;
            bajo_q <= '0;
        end else if (load_i) begin
            alto_q <= alto_i;
            bajo_q <= bajo_i;
        end
    end

    // Judged on the live inputs: they are what gets latched on the INIT exit edge.
    assign cfg_ok_o = (bajo_i < alto_i);
    assign alto_o   = alto_q;
    assign bajo_o   = bajo_q;

endmodule

`default_nettype wire

// File: rtl/fsm_control.sv
// ============================================================================
// Module   : fsm_control
// Brief    : Moore control FSM for the output FIFO stage (RESET/INIT/IDLE/
//            ACTIVE/ERROR), with fault-source capture and threshold ownership.
//            Optional macro IDLE_DEBOUNCE_EN: ACTIVE->IDLE needs IDLE_HOLD
//            consecutive all-empty cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_control
    import fsm_control_pkg::*;
#(
    parameter int FIFO_UNITS = 4,
    parameter int THR_WIDTH  = 3,
    parameter int IDLE_HOLD  = 2
) (
    input  logic         clk,
    input  logic         reset,
    fsm_control_if.slave bus_io
);

    state_e                state_q;
    state_e                state_d;
    logic                  idle_q;
    logic                  active_q;
    logic                  error_q;
    logic [FIFO_UNITS-1:0] error_src_q;
    logic [FIFO_UNITS-1:0] error_src_d;

    logic                  w_all_empty;
    logic                  w_any_error;
    logic                  w_load;
    logic                  w_cfg_ok;
    logic                  w_idle_go;
    logic [THR_WIDTH-1:0]  w_alto;
    logic [THR_WIDTH-1:0]  w_bajo;

    assign w_all_empty = &bus_io.fifo_empty;
    assign w_any_error = |bus_io.fifo_error;
    assign w_load      = (state_q == S_INIT);

    fsm_control_threshold_regs #(
        .THR_WIDTH (THR_WIDTH)
    ) u_thr (
        .clk      (clk),
        .reset    (reset),
        .load_i   (w_load),
        .alto_i   (bus_io.umbral_alto_in),
        .bajo_i   (bus_io.umbral_bajo_in),
        .alto_o   (w_alto),
        .bajo_o   (w_bajo),
        .cfg_ok_o (w_cfg_ok)
    );

`ifdef IDLE_DEBOUNCE_EN
    localparam int               c_cnt_w = clog2(IDLE_HOLD + 1);
    localparam logic [c_cnt_w-1:0] c_hold = c_cnt_w'(IDLE_HOLD);

    logic [c_cnt_w-1:0] hold_cnt_q;
    logic [c_cnt_w-1:0] w_hold_inc;

    assign w_hold_inc = (hold_cnt_q == c_hold) ? hold_cnt_q : hold_cnt_q + 1'b1;
    assign w_idle_go  = w_all_empty && (w_hold_inc == c_hold);

    // Any exit from ACTIVE (including to IDLE) leaves the count at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_q <= '0;
        end else if ((state_d == S_ACTIVE) && w_all_empty) begin
            hold_cnt_q <= w_hold_inc;
        end else begin
            hold_cnt_q <= '0;
        end
    end
`else
    assign w_idle_go = w_all_empty;
`endif

    always_comb begin
        state_d     = state_q;
        error_src_d = error_src_q;
        case (state_q)
            S_RESET: begin
                state_d = S_INIT;
            end
            S_INIT: begin
                if (!bus_io.init) begin
                    if (w_cfg_ok) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d     = S_ERROR;
                        error_src_d = '0;
                    end
                end
            end
            S_IDLE: begin
                if (w_any_error) begin
                    state_d     = S_ERROR;
                    error_src_d = bus_io.fifo_error;
                end else if (bus_io.init) begin
                    state_d = S_INIT;
                end else if (!w_all_empty) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_any_error) begin
                    state_d     = S_ERROR;
                    error_src_d = bus_io.fifo_error;
                end else if (bus_io.init) begin
                    state_d = S_INIT;
                end else if (w_idle_go) begin
                    state_d = S_IDLE;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    // Flags are registered from the next state so they line up with estado.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RESET;
            idle_q      <= 1'b0;
            active_q    <= 1'b0;
            error_q     <= 1'b0;
            error_src_q <= '0;
        end else begin
            state_q     <= state_d;
            idle_q      <= (state_d == S_IDLE);
            active_q    <= (state_d == S_ACTIVE);
            error_q     <= (state_d == S_ERROR);
            error_src_q <= error_src_d;
        end
    end

    assign bus_io.umbral_alto = w_alto;
    assign bus_io.umbral_bajo = w_bajo;
    assign bus_io.idle        = idle_q;
    assign bus_io.active      = active_q;
    assign bus_io.error       = error_q;
    assign bus_io.error_src   = error_src_q;
    assign bus_io.estado      = state_q;

endmodule

`default_nettype wire
